// File: rtl/rr_reg_bank_arbiter.sv
// rr_reg_bank_arbiter
//
// Round-robin arbiter and access sequencer for a small bank of data
// registers shared by NUM_REQ requesters. Each requester issues a single
// read or write through a req/gnt/ack handshake. Accesses are serialised
// through a three-state FSM (IDLE -> GRANT -> ACK), so at most one access
// completes every three cycles. The whole bank is also exposed continuously
// on regs_o for downstream logic.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous reset, active-high
//   req_i    per-requester request, held high until ack
//   we_i     per-requester write enable (1 = write, 0 = read)
//   addr_i   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata_i  packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt_o    registered one-hot grant
//   ack_o    one-cycle completion pulse for the granted requester
//   err_o    valid with ack_o: the access addressed a register >= NUM_REGS
//   rdata_o  read data, valid while ack_o is high, held until the next
//            read or error completion
//   regs_o   packed contents of all registers, register r at [r*DATA_W +: DATA_W]
//
// Optional feature macro: RR_REQ0_PRIO_EN
//   When defined, requester 0 has fixed highest priority and requesters
//   1..NUM_REQ-1 rotate among themselves. When undefined, pure round-robin
//   across all requesters.

module rr_reg_bank_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       ack_o,
  output logic                       err_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACK
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    gntIdx_q, gntIdx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                pickValid;
  logic [IDX_W-1:0]    pickIdx;
  int                  scanIdx;

  logic                curReq;
  logic                curWe;
  logic [ADDR_W-1:0]   curAddr;
  logic [DATA_W-1:0]   curWdata;
  logic                inRange;
  logic [DATA_W-1:0]   readVal;

  logic                wrEn;
  logic [ADDR_W-1:0]   wrAddr;
  logic [DATA_W-1:0]   wrData;

  // Arbitration: scan last+1, last+2, ... with wrap so the most recently
  // served requester is considered last. With the priority option, a
  // pending req[0] claims the grant before the scan, and the scan cannot
  // override it because it only takes the first hit while nothing is picked.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    scanIdx   = 0;
`ifdef RR_REQ0_PRIO_EN
    if (req_i[0]) begin
      pickValid = 1'b1;
      pickIdx   = '0;
    end
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      scanIdx = (int'(last_q) + k) % NUM_REQ;
      if (!pickValid && req_i[IDX_W'(scanIdx)]) begin
        pickValid = 1'b1;
        pickIdx   = IDX_W'(scanIdx);
      end
    end
  end

  // Fields of the currently granted requester, sampled at the GRANT edge.
  // The extra leading zero keeps the range compare meaningful when the bank
  // fills the whole address space.
  always_comb begin
    curReq   = req_i[gntIdx_q];
    curWe    = we_i[gntIdx_q];
    curAddr  = addr_i[int'(gntIdx_q)*ADDR_W +: ADDR_W];
    curWdata = wdata_i[int'(gntIdx_q)*DATA_W +: DATA_W];
    inRange  = ({1'b0, curAddr} < (ADDR_W+1)'(NUM_REGS));
  end

  // Read mux written as a compare loop so an out-of-range address never
  // indexes past the end of the bank.
  always_comb begin
    readVal = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (curAddr == ADDR_W'(r)) begin
        readVal = regs_q[r];
      end
    end
  end

  // Next-state and datapath control. ack/err default low so they pulse for
  // exactly the one ACK cycle; rdata and the pointer hold unless an access
  // completes. An aborted grant (req dropped) returns to IDLE with no side
  // effects and leaves the rotation pointer alone.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gntIdx_d = gntIdx_q;
    last_d   = last_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    wrEn     = 1'b0;
    wrAddr   = curAddr;
    wrData   = curWdata;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pickValid) begin
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
          gntIdx_d = pickIdx;
          state_d  = GRANT;
        end
      end

      GRANT: begin
        gnt_d   = '0;
        state_d = IDLE;
        if (curReq) begin
          ack_d   = 1'b1;
          state_d = ACK;
`ifdef RR_REQ0_PRIO_EN
          if (gntIdx_q != '0) begin
            last_d = gntIdx_q;
          end
`else
          last_d = gntIdx_q;
`endif
          if (!inRange) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (curWe) begin
            wrEn = 1'b1;
          end else begin
            rdata_d = readVal;
          end
        end
      end

      ACK: begin
        gnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM and handshake registers. Reset points the rotation at the last
  // requester so requester 0 is served first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gntIdx_q <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gntIdx_q <= gntIdx_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Register bank. A reset during GRANT wins over the pending write, so an
  // in-flight write is discarded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wrEn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wrAddr == ADDR_W'(r)) begin
          regs_q[r] <= wrData;
        end
      end
    end
  end

  // Flatten the bank onto the packed output.
  always_comb begin
    regs_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_o[r*DATA_W +: DATA_W] = regs_q[r];
    end
  end

  assign gnt_o   = gnt_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_rr_reg_bank_arbiter.sv
// tb_rr_reg_bank_arbiter
//
// Directed testbench for rr_reg_bank_arbiter, built with NUM_REQ=4,
// DATA_W=4, NUM_REGS=3, ADDR_W=2 so that address 3 is out of range.
// Expected values are hand-computed; expectations that depend on the
// RR_REQ0_PRIO_EN macro are selected with the same macro.

module tb_rr_reg_bank_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 4;
  localparam int NUM_REGS = 3;
  localparam int ADDR_W   = 2;

  logic                       clk;
  logic                       rst;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         we;
  logic [NUM_REQ*ADDR_W-1:0]  addr;
  logic [NUM_REQ*DATA_W-1:0]  wdata;
  logic [NUM_REQ-1:0]         gnt;
  logic                       ack;
  logic                       err;
  logic [DATA_W-1:0]          rdata;
  logic [NUM_REGS*DATA_W-1:0] regsOut;

  int total;
  int bad;

  rr_reg_bank_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .gnt_o   (gnt),
    .ack_o   (ack),
    .err_o   (err),
    .rdata_o (rdata),
    .regs_o  (regsOut)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled at this point, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one requester's request fields.
  task automatic setReq(input int idx, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    req[idx]                    = 1'b1;
    we[idx]                     = wr;
    addr[idx*ADDR_W +: ADDR_W]  = a;
    wdata[idx*DATA_W +: DATA_W] = d;
  endtask

  // Synchronous-looking reset pulse spanning one clock edge.
  task automatic applyStimulus_reset();
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    tick();
    rst = 1'b0;
  endtask

  // Run one isolated access through GRANT and ACK, returning what was seen.
  task automatic runAccess(input int idx, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d,
                           output logic [NUM_REQ-1:0] gntSeen, output logic ackSeen,
                           output logic errSeen, output logic [DATA_W-1:0] rdSeen,
                           output logic [NUM_REGS*DATA_W-1:0] regsSeen);
    setReq(idx, wr, a, d);
    tick();
    gntSeen = gnt;
    tick();
    ackSeen  = ack;
    errSeen  = err;
    rdSeen   = rdata;
    regsSeen = regsOut;
    req[idx] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = '1;
    we    = '1;
    addr  = '0;
    wdata = '1;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    total++; if (rdata !== 4'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    total++; if (regsOut !== 12'h000) begin bad++; $display("[TB] FAIL reset_regs: got %h expected 000", regsOut); end
    req   = '0;
    we    = '0;
    wdata = '0;
    rst   = 1'b0;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL idle_gnt: got %b expected %b", gnt, 4'b0000); end
  endtask

  task automatic test_single_write_read();
    logic [NUM_REQ-1:0]         g;
    logic                       a, e;
    logic [DATA_W-1:0]          rd;
    logic [NUM_REGS*DATA_W-1:0] rg;
    applyStimulus_reset();
    runAccess(2, 1'b1, 2'd1, 4'hA, g, a, e, rd, rg);
    total++; if (g !== 4'b0100) begin bad++; $display("[TB] FAIL wr_gnt: got %b expected %b", g, 4'b0100); end
    total++; if (a !== 1'b1) begin bad++; $display("[TB] FAIL wr_ack: got %b expected 1", a); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL wr_err: got %b expected 0", e); end
    total++; if (rg !== 12'h0A0) begin bad++; $display("[TB] FAIL wr_regs: got %h expected 0a0", rg); end
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL wr_ack_pulse: got %b expected 0", ack); end
    runAccess(0, 1'b0, 2'd1, 4'h0, g, a, e, rd, rg);
    total++; if (g !== 4'b0001) begin bad++; $display("[TB] FAIL rd_gnt: got %b expected %b", g, 4'b0001); end
    total++; if (a !== 1'b1) begin bad++; $display("[TB] FAIL rd_ack: got %b expected 1", a); end
    total++; if (rd !== 4'hA) begin bad++; $display("[TB] FAIL rd_data: got %h expected a", rd); end
    total++; if (rdata !== 4'hA) begin bad++; $display("[TB] FAIL rd_hold: got %h expected a", rdata); end
  endtask

  task automatic test_round_robin();
    int                 expIdx;
    logic [NUM_REQ-1:0] expGnt;
    applyStimulus_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      setReq(i, 1'b1, ADDR_W'(i % NUM_REGS), DATA_W'(i + 1));
    end
    for (int k = 0; k < 5; k++) begin
`ifdef RR_REQ0_PRIO_EN
      expIdx = 0;
`else
      expIdx = k % NUM_REQ;
`endif
      expGnt = 4'b0001 << expIdx;
      tick();
      total++; if (gnt !== expGnt) begin bad++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, expGnt); end
      total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL rr_ack_early[%0d]: got %b expected 0", k, ack); end
      tick();
      total++; if (ack !== 1'b1 || gnt !== 4'b0000) begin bad++; $display("[TB] FAIL rr_ack[%0d]: got ack=%b gnt=%b expected ack=1 gnt=0000", k, ack, gnt); end
      tick();
      total++; if (ack !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("[TB] FAIL rr_gap[%0d]: got ack=%b gnt=%b expected ack=0 gnt=0000", k, ack, gnt); end
    end
    req = '0;
    tick();
`ifdef RR_REQ0_PRIO_EN
    total++; if (regsOut !== 12'h001) begin bad++; $display("[TB] FAIL rr_regs: got %h expected 001", regsOut); end
`else
    total++; if (regsOut !== 12'h321) begin bad++; $display("[TB] FAIL rr_regs: got %h expected 321", regsOut); end
`endif
  endtask

  task automatic test_abort();
    applyStimulus_reset();
    setReq(1, 1'b1, 2'd2, 4'h7);
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL abort_gnt: got %b expected %b", gnt, 4'b0010); end
    req[1] = 1'b0;
    tick();
    total++; if (ack !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("[TB] FAIL abort_noack: got ack=%b gnt=%b expected ack=0 gnt=0000", ack, gnt); end
    total++; if (regsOut !== 12'h000) begin bad++; $display("[TB] FAIL abort_regs: got %h expected 000", regsOut); end
    setReq(1, 1'b1, 2'd2, 4'h7);
    setReq(3, 1'b1, 2'd2, 4'h9);
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL abort_next: got %b expected %b", gnt, 4'b0010); end
    tick();
    total++; if (regsOut !== 12'h700) begin bad++; $display("[TB] FAIL abort_wr1: got %h expected 700", regsOut); end
    req[1] = 1'b0;
    tick();
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL abort_then3: got %b expected %b", gnt, 4'b1000); end
    tick();
    total++; if (regsOut !== 12'h900) begin bad++; $display("[TB] FAIL abort_wr3: got %h expected 900", regsOut); end
    req = '0;
    tick();
  endtask

  task automatic test_out_of_range();
    logic [NUM_REQ-1:0]         g;
    logic                       a, e;
    logic [DATA_W-1:0]          rd;
    logic [NUM_REGS*DATA_W-1:0] rg;
    applyStimulus_reset();
    runAccess(0, 1'b1, 2'd0, 4'h6, g, a, e, rd, rg);
    runAccess(0, 1'b0, 2'd0, 4'h0, g, a, e, rd, rg);
    total++; if (rd !== 4'h6) begin bad++; $display("[TB] FAIL oor_pre_read: got %h expected 6", rd); end
    runAccess(1, 1'b1, 2'd3, 4'hF, g, a, e, rd, rg);
    total++; if (a !== 1'b1 || e !== 1'b1) begin bad++; $display("[TB] FAIL oor_wr_ackerr: got ack=%b err=%b expected ack=1 err=1", a, e); end
    total++; if (rg !== 12'h006) begin bad++; $display("[TB] FAIL oor_wr_regs: got %h expected 006", rg); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL oor_err_pulse: got %b expected 0", err); end
    runAccess(2, 1'b0, 2'd3, 4'h0, g, a, e, rd, rg);
    total++; if (a !== 1'b1 || e !== 1'b1) begin bad++; $display("[TB] FAIL oor_rd_ackerr: got ack=%b err=%b expected ack=1 err=1", a, e); end
    total++; if (rd !== 4'h0) begin bad++; $display("[TB] FAIL oor_rd_data: got %h expected 0", rd); end
  endtask

  task automatic test_reset_mid_access();
    applyStimulus_reset();
    setReq(3, 1'b1, 2'd2, 4'h5);
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL mid_gnt: got %b expected %b", gnt, 4'b1000); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000 || ack !== 1'b0) begin bad++; $display("[TB] FAIL mid_async: got gnt=%b ack=%b expected gnt=0000 ack=0", gnt, ack); end
    tick();
    total++; if (regsOut !== 12'h000) begin bad++; $display("[TB] FAIL mid_regs: got %h expected 000", regsOut); end
    rst = 1'b0;
    setReq(0, 1'b0, 2'd0, 4'h0);
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL mid_first: got %b expected %b", gnt, 4'b0001); end
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL mid_retry: got %b expected %b", gnt, 4'b1000); end
    tick();
    total++; if (regsOut !== 12'h500) begin bad++; $display("[TB] FAIL mid_retry_regs: got %h expected 500", regsOut); end
    req = '0;
    tick();
  endtask

  task automatic test_req0_contention();
    int                 expIdx;
    logic [NUM_REQ-1:0] expGnt;
    applyStimulus_reset();
    setReq(0, 1'b0, 2'd0, 4'h0);
    setReq(3, 1'b0, 2'd1, 4'h0);
    for (int k = 0; k < 3; k++) begin
`ifdef RR_REQ0_PRIO_EN
      expIdx = 0;
`else
      expIdx = (k % 2 == 0) ? 0 : 3;
`endif
      expGnt = 4'b0001 << expIdx;
      tick();
      total++; if (gnt !== expGnt) begin bad++; $display("[TB] FAIL mix_gnt[%0d]: got %b expected %b", k, gnt, expGnt); end
      tick();
      tick();
    end
    req[0] = 1'b0;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL mix_drop0: got %b expected %b", gnt, 4'b1000); end
    req = '0;
    tick();
    tick();
  endtask

  // Scenario sequence and final summary.
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    test_reset();
    test_single_write_read();
    test_round_robin();
    test_abort();
    test_out_of_range();
    test_reset_mid_access();
    test_req0_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
